// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receiver (8N1, LSB first) with a small APB read-only
//   register window. The serial line is synchronized by two flops; the byte
//   becomes visible in RX_DATA only when the stop bit is high.
//
//   Optional feature macro: UART_RX_PARITY_EN. When it is defined, an even
//   parity bit follows the data bits and a mismatch sets PERR.
//
// Ports
//   PCLK         single clock
//   PRESETn      asynchronous active-low reset
//   PSEL         APB select
//   PENABLE      APB access phase
//   PWRITE       APB direction (1 = write; writes are accepted and ignored)
//   PADDR[7:0]   APB byte address (0x80 RX_DATA, 0x84 STATUS)
//   PRDATA[7:0]  APB read data, 0x00 outside a read access phase
//   PREADY       high during every access phase (no wait states)
//   i_Rx_Serial  asynchronous serial input, idle high
//   o_Rx_Done    one-cycle pulse per accepted frame
//
// State     | meaning
// IDLE      | line idle, waiting for a synchronized low
// START_BIT | counting to mid start bit to reject glitches
// DATA_BITS | sampling 8 data bits, one per bit period
// PARITY_BIT| sampling even parity (UART_RX_PARITY_EN only)
// STOP_BIT  | sampling stop bit, then publish or flag framing error

module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Done
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
`endif

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        done_q, done_d;
  logic        perr_bit;
`ifdef UART_RX_PARITY_EN
  logic        perr_q, perr_d;
  logic        par_bad_q, par_bad_d;
  logic        par_err;
`endif

  logic        frame_good;
  logic        frame_ferr;
  logic        apb_rd;
  logic        rd_data;
  logic        rd_status;
  logic [7:0]  status;

  assign apb_rd    = PSEL & PENABLE & ~PWRITE;
  assign rd_data   = apb_rd & (PADDR == 8'h80);
  assign rd_status = apb_rd & (PADDR == 8'h84);

`ifdef UART_RX_PARITY_EN
  assign perr_bit = perr_q;
`else
  assign perr_bit = 1'b0;
`endif

  assign status = {4'h0, perr_bit, ferr_q, ovr_q, valid_q};

  // Reset is folded in so the bus outputs are quiet while PRESETn is low,
  // even if a master holds PSEL/PENABLE.
  always_comb begin
    PREADY = PSEL & PENABLE & PRESETn;
    PRDATA = 8'h00;
    if (PRESETn && apb_rd && PADDR[7]) begin
      if (PADDR == 8'h80)      PRDATA = rx_data_q;
      else if (PADDR == 8'h84) PRDATA = status;
      else                     PRDATA = 8'h00;
    end
  end

  assign o_Rx_Done = done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    frame_good = 1'b0;
    frame_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
    par_bad_d  = par_bad_q;
    par_err    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d     = 8'd0;
        bit_idx_d = 3'd0;
        if (!rx_sync_q) begin
          state_d = START_BIT;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START_BIT: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = 8'd0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rx_sync_q ? IDLE : DATA_BITS;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA_BITS: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 8'd0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY_BIT;
`else
            state_d = STOP_BIT;
`endif
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 8'd0;
          state_d = STOP_BIT;
          if ((^shift_q) != rx_sync_q) begin
            par_err   = 1'b1;
            par_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      STOP_BIT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
          if (!rx_sync_q) begin
            frame_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!par_bad_q) begin
`else
          end else begin
`endif
            frame_good = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Read side effects first, so a frame landing on the same edge wins.
    if (rd_data) valid_d = 1'b0;
    if (rd_status) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d = 1'b0;
`endif
    end

    if (frame_good) begin
      rx_data_d = shift_q;
      valid_d   = 1'b1;
      done_d    = 1'b1;
      // Byte being read on this edge is not lost, so no overrun.
      if (valid_q && !rd_data) ovr_d = 1'b1;
    end
    if (frame_ferr) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (par_err) perr_d = 1'b1;
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      cnt_q     <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with CLKS_PER_BIT = 8. Bytes expected to
// be accepted are queued as frames are sent; each o_Rx_Done pops one, and
// RX_DATA reads are checked against the last popped byte.
module tb_uart_receiver;
  localparam int CPB = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       PSEL = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PADDR = 8'h00;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       rx_line = 1'b1;
  logic       rx_done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int d0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;

  always #5 PCLK = ~PCLK;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PRDATA(PRDATA), .PREADY(PREADY),
    .i_Rx_Serial(rx_line), .o_Rx_Done(rx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (rx_done) begin
      done_cnt++;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL done_unexpected observed_pulse=1 expected_pulse=0");
      end
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_ok, input logic good);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`endif
    if (good) exp_q.push_back(d);
    send_bit(stop_b);
    rx_line = 1'b1;
    tick(6);
  endtask

  task automatic apb_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    logic [7:0] data;
    logic       rdy;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    tick(1);
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA;
    rdy  = PREADY;
    check({tag, "_pready"}, {31'd0, rdy}, 32'd1);
    check(tag, {24'd0, data}, {24'd0, exp});
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    tick(1);
  endtask

  task automatic apb_write(input logic [7:0] addr, input string tag);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PENABLE = 1'b0;
    tick(1);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check({tag, "_pready"}, {31'd0, PREADY}, 32'd1);
    check({tag, "_prdata"}, {24'd0, PRDATA}, 32'd0);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state with a master holding an access phase.
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h84;
    tick(3);
    @(negedge PCLK);
    check("rst_prdata", {24'd0, PRDATA}, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_done", {31'd0, rx_done}, 32'd0);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b1;
    tick(3);
    @(negedge PCLK);
    check("idle_pready", {31'd0, PREADY}, 32'd0);
    tick(1);
    apb_read(8'h84, 8'h00, "rst_status");
    apb_read(8'h80, 8'h00, "rst_rxdata");

    // Framing error: byte discarded.
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("ferr_no_done", done_cnt - d0, 32'd0);
    apb_read(8'h84, 8'h04, "ferr_status");
    apb_read(8'h80, 8'h00, "ferr_rxdata");
    apb_read(8'h84, 8'h00, "ferr_cleared");

    // Good frame.
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check("a5_done_once", done_cnt - d0, 32'd1);
    apb_read(8'h84, 8'h01, "a5_status");
    apb_read(8'h80, last_exp, "a5_rxdata");
    apb_read(8'h84, 8'h00, "a5_status_after");

    // Two-cycle low glitch on idle line.
    d0 = done_cnt;
    rx_line = 1'b0;
    tick(2);
    rx_line = 1'b1;
    tick(20);
    check("glitch_no_done", done_cnt - d0, 32'd0);
    apb_read(8'h84, 8'h00, "glitch_status");

    // Overrun.
    d0 = done_cnt;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1);
    check("ovr_two_done", done_cnt - d0, 32'd2);
    apb_read(8'h84, 8'h03, "ovr_status");
    apb_read(8'h80, last_exp, "ovr_rxdata");
    apb_read(8'h84, 8'h00, "ovr_cleared");

    // Writes are ignored; unmapped reads return zero.
    apb_write(8'h80, "wr_rxdata");
    apb_write(8'h84, "wr_status");
    apb_read(8'h80, 8'h22, "wr_rxdata_kept");
    apb_read(8'h84, 8'h00, "wr_status_kept");
    apb_read(8'h88, 8'h00, "unmapped_88");
    apb_read(8'h04, 8'h00, "unmapped_04");

    // Reset during data bit 4 of 0xFF, then a clean frame.
    d0 = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_line = 1'b1;
    tick(4);
    PRESETn = 1'b0;
    tick(3);
    PRESETn = 1'b1;
    tick(12);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    check("midrst_done", done_cnt - d0, 32'd1);
    apb_read(8'h84, 8'h01, "midrst_status");
    apb_read(8'h80, 8'h5A, "midrst_rxdata");

`ifdef UART_RX_PARITY_EN
    d0 = done_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("perr_no_done", done_cnt - d0, 32'd0);
    apb_read(8'h84, 8'h08, "perr_status");
    apb_read(8'h84, 8'h00, "perr_cleared");
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
